// File: rtl/pipeline_ctrl_if.sv
// Pipeline control bus: hazard/memory/halt requests in, register enables and status out.
interface pipeline_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             data_hz;
    logic             br_taken;
    logic             imem_busy;
    logic             dmem_busy;
    logic             halt_id;
    logic             halt_wb;
    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_bubble;
    logic [2:0]       state;
    logic             halted;
    logic             err;
    logic [CNT_W-1:0] stall_cnt;

    // Datapath side: raises requests, consumes enables/status.
    modport master (
        output data_hz, br_taken, imem_busy, dmem_busy, halt_id, halt_wb,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_bubble,
        input  state, halted, err, stall_cnt
    );

    // Controller side.
    modport slave (
        input  data_hz, br_taken, imem_busy, dmem_busy, halt_id, halt_wb,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_bubble,
        output state, halted, err, stall_cnt
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline controller: stall/flush/bubble arbitration, HALT drain
// sequencing, protocol-violation detection and stall-cycle accounting.
module pipeline_ctrl #(
    parameter int CNT_W     = 16,
    parameter int DHZ_MAX   = 2,
    parameter int DRAIN_MAX = 4
) (
    input logic            clk,
    input logic            rst,
    pipeline_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        RUN     = 3'd0,
        MEMWAIT = 3'd1,
        DRAIN   = 3'd2,
        HALTED  = 3'd3
    } state_e;

    localparam int DRN_W = $clog2(DRAIN_MAX + 1);
    localparam int HZ_W  = $clog2(DHZ_MAX + 2);
    // Drain counter value on the last allowed advancing cycle.
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_MAX - 1);
    localparam logic [HZ_W-1:0]  HZ_MAX   = HZ_W'(DHZ_MAX);
    // Hazard counter parks one past the limit so it never wraps.
    localparam logic [HZ_W-1:0]  HZ_SAT   = HZ_W'(DHZ_MAX + 1);

    state_e           r_state, w_next;
    logic [DRN_W-1:0] r_drain_cnt, w_drain_nxt;
    logic [HZ_W-1:0]  r_hz_cnt, w_hz_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             r_err, w_err_set;
    logic             w_p3, w_stall_inc;
    logic             w_pc_en, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en;
    logic             w_flush, w_bubble;

    // Priority arbitration of enables plus next-state / counter decisions.
    always_comb begin
        w_pc_en     = 1'b0;
        w_ifid_en   = 1'b0;
        w_idex_en   = 1'b0;
        w_exmem_en  = 1'b0;
        w_memwb_en  = 1'b0;
        w_flush     = 1'b0;
        w_bubble    = 1'b0;
        w_next      = r_state;
        w_drain_nxt = r_drain_cnt;
        w_p3        = 1'b0;
        w_err_set   = 1'b0;
        if (rst) begin
            case (r_state)
                HALTED: ;
                DRAIN: begin
                    if (bus.dmem_busy) begin
                        // Freeze: nothing advances, drain budget not consumed.
                    end else if (bus.br_taken) begin
                        // HALT was on the wrong path; redirect and resume.
                        {w_pc_en, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en} = '1;
                        w_flush  = 1'b1;
                        w_bubble = 1'b1;
                        w_next   = RUN;
                    end else begin
                        w_ifid_en  = 1'b1;
                        w_idex_en  = 1'b1;
                        w_exmem_en = 1'b1;
                        w_memwb_en = 1'b1;
                        w_flush    = 1'b1;
                        w_bubble   = 1'b1;
                        if (bus.halt_wb) begin
                            w_next = HALTED;
                        end else if (r_drain_cnt == DRN_LAST) begin
                            w_next    = HALTED;
                            w_err_set = 1'b1;
                        end else begin
                            w_drain_nxt = r_drain_cnt + 1'b1;
                        end
                    end
                end
                // MEMWAIT with memory ready behaves exactly like RUN.
                default: begin
                    if (bus.dmem_busy) begin
                        w_next = MEMWAIT;
                    end else if (bus.br_taken) begin
                        {w_pc_en, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en} = '1;
                        w_flush  = 1'b1;
                        w_bubble = 1'b1;
                        w_next   = RUN;
                    end else if (bus.data_hz) begin
                        w_idex_en  = 1'b1;
                        w_exmem_en = 1'b1;
                        w_memwb_en = 1'b1;
                        w_bubble   = 1'b1;
                        w_p3       = 1'b1;
                        w_next     = RUN;
                        if (r_hz_cnt >= HZ_MAX) w_err_set = 1'b1;
                    end else begin
                        {w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en} = '1;
                        w_pc_en = !bus.imem_busy;
                        w_flush = bus.imem_busy;
                        if (bus.halt_id) begin
                            w_next      = DRAIN;
                            w_drain_nxt = '0;
                        end else begin
                            w_next = RUN;
                        end
                    end
                end
            endcase
        end
    end

    assign w_hz_nxt    = w_p3 ? ((r_hz_cnt == HZ_SAT) ? HZ_SAT : r_hz_cnt + 1'b1) : '0;
    assign w_stall_inc = (r_state != HALTED) && !w_pc_en && (r_stall_cnt != '1);

    // State, counters and sticky error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= RUN;
            r_drain_cnt <= '0;
            r_hz_cnt    <= '0;
            r_stall_cnt <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_drain_cnt <= w_drain_nxt;
            r_hz_cnt    <= w_hz_nxt;
            if (w_stall_inc) r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_err_set)   r_err       <= 1'b1;
        end
    end

    assign bus.pc_en       = w_pc_en;
    assign bus.ifid_en     = w_ifid_en;
    assign bus.idex_en     = w_idex_en;
    assign bus.exmem_en    = w_exmem_en;
    assign bus.memwb_en    = w_memwb_en;
    assign bus.ifid_flush  = w_flush;
    assign bus.idex_bubble = w_bubble;
    assign bus.state       = r_state;
    assign bus.halted      = (r_state == HALTED);
    assign bus.err         = r_err;
    assign bus.stall_cnt   = r_stall_cnt;
endmodule
